// File: rtl/cdb_if.sv
// Common data bus bundle: FU completion ports with back-pressure plus the registered broadcast.
// master = FU/ROB side, slave = the cdb arbiter.
interface cdb_if #(
  parameter int unsigned NUM_FU      = 4,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ROB_IDX_LEN = 5
);
  logic [NUM_FU-1:0]                  fu_valid;
  logic [NUM_FU-1:0][ROB_IDX_LEN-1:0] fu_entry_idx;
  logic [NUM_FU-1:0][XLEN-1:0]        fu_value;
  logic [NUM_FU-1:0]                  fu_mis_pred;
  logic [NUM_FU-1:0]                  fu_ready;
  logic                               cdb_valid;
  logic [ROB_IDX_LEN-1:0]             cdb_entry_idx;
  logic [XLEN-1:0]                    cdb_value;
  logic                               cdb_mis_pred;

  modport master (
    output fu_valid, fu_entry_idx, fu_value, fu_mis_pred,
    input  fu_ready, cdb_valid, cdb_entry_idx, cdb_value, cdb_mis_pred
  );

  modport slave (
    input  fu_valid, fu_entry_idx, fu_value, fu_mis_pred,
    output fu_ready, cdb_valid, cdb_entry_idx, cdb_value, cdb_mis_pred
  );
endinterface

// File: rtl/cdb.sv
// Common data bus arbiter: one holding slot per FU, round-robin grant onto a registered broadcast.
// Define CDB_BYPASS_EN to let an empty slot's incoming completion compete in the same cycle.
module cdb #(
  parameter int unsigned NUM_FU      = 4,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ROB_IDX_LEN = 5
) (
  input logic  clock,
  input logic  reset,
  input logic  squash,
  cdb_if.slave bus
);
  localparam int unsigned PtrW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int unsigned SumW = PtrW + 1;
  localparam logic [PtrW-1:0] LastIdx = PtrW'(NUM_FU - 1);

  logic [NUM_FU-1:0]                  slot_valid_q, slot_valid_d;
  logic [NUM_FU-1:0][ROB_IDX_LEN-1:0] slot_idx_q, slot_idx_d;
  logic [NUM_FU-1:0][XLEN-1:0]        slot_value_q, slot_value_d;
  logic [NUM_FU-1:0]                  slot_mp_q, slot_mp_d;
  logic [PtrW-1:0]                    rr_ptr_q, rr_ptr_d;

  logic                   cdb_valid_q, cdb_valid_d;
  logic [ROB_IDX_LEN-1:0] cdb_idx_q, cdb_idx_d;
  logic [XLEN-1:0]        cdb_value_q, cdb_value_d;
  logic                   cdb_mp_q, cdb_mp_d;

  logic [NUM_FU-1:0] cand, grant, sure_grant, bypass_win, fu_ready, take;
  logic [PtrW-1:0]   grant_idx;
  logic              any_grant;

  logic [ROB_IDX_LEN-1:0] sel_idx;
  logic [XLEN-1:0]        sel_value;
  logic                   sel_mp;

`ifdef CDB_BYPASS_EN
  assign cand       = slot_valid_q | bus.fu_valid;
  assign bypass_win = grant & ~slot_valid_q;
  // Only an occupied slot at rr_ptr is known to win without looking at fu_valid.
  always_comb begin
    sure_grant           = '0;
    sure_grant[rr_ptr_q] = slot_valid_q[rr_ptr_q];
  end
`else
  assign cand       = slot_valid_q;
  assign bypass_win = '0;
  assign sure_grant = grant;
`endif

  always_comb begin
    logic [SumW-1:0] sum;
    logic [PtrW-1:0] j;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      sum = {1'b0, rr_ptr_q} + SumW'(k);
      if (sum >= SumW'(NUM_FU)) sum = sum - SumW'(NUM_FU);
      j = sum[PtrW-1:0];
      if (!any_grant && !squash && cand[j]) begin
        grant[j]  = 1'b1;
        grant_idx = j;
        any_grant = 1'b1;
      end
    end
  end

  assign fu_ready = squash ? '1 : (~slot_valid_q | sure_grant);
  assign take     = bus.fu_valid & fu_ready & {NUM_FU{~squash}} & ~bypass_win;

  always_comb begin
    sel_idx   = '0;
    sel_value = '0;
    sel_mp    = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant[i]) begin
        if (slot_valid_q[i]) begin
          sel_idx   = slot_idx_q[i];
          sel_value = slot_value_q[i];
          sel_mp    = slot_mp_q[i];
        end else begin
          sel_idx   = bus.fu_entry_idx[i];
          sel_value = bus.fu_value[i];
          sel_mp    = bus.fu_mis_pred[i];
        end
      end
    end
  end

  always_comb begin
    slot_valid_d = slot_valid_q & ~grant;
    slot_idx_d   = slot_idx_q;
    slot_value_d = slot_value_q;
    slot_mp_d    = slot_mp_q;
    for (int i = 0; i < NUM_FU; i++) begin
      if (take[i]) begin
        slot_valid_d[i] = 1'b1;
        slot_idx_d[i]   = bus.fu_entry_idx[i];
        slot_value_d[i] = bus.fu_value[i];
        slot_mp_d[i]    = bus.fu_mis_pred[i];
      end
    end
    if (squash) slot_valid_d = '0;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_grant) rr_ptr_d = (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
  end

  // Data fields hold their last broadcast when nothing is granted.
  assign cdb_valid_d = any_grant;
  assign cdb_idx_d   = any_grant ? sel_idx : cdb_idx_q;
  assign cdb_value_d = any_grant ? sel_value : cdb_value_q;
  assign cdb_mp_d    = any_grant ? sel_mp : cdb_mp_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_valid_q <= '0;
      slot_idx_q   <= '0;
      slot_value_q <= '0;
      slot_mp_q    <= '0;
      rr_ptr_q     <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_idx_q    <= '0;
      cdb_value_q  <= '0;
      cdb_mp_q     <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_idx_q   <= slot_idx_d;
      slot_value_q <= slot_value_d;
      slot_mp_q    <= slot_mp_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_idx_q    <= cdb_idx_d;
      cdb_value_q  <= cdb_value_d;
      cdb_mp_q     <= cdb_mp_d;
    end
  end

  assign bus.fu_ready      = fu_ready;
  assign bus.cdb_valid     = cdb_valid_q;
  assign bus.cdb_entry_idx = cdb_idx_q;
  assign bus.cdb_value     = cdb_value_q;
  assign bus.cdb_mis_pred  = cdb_mp_q;
endmodule

// File: tb/tb_cdb.sv
// Self-checking bench for cdb in its default build (CDB_BYPASS_EN undefined): cycle table plus
// a two-FU fairness run checked against per-FU expected queues.
module tb_cdb;
  localparam int unsigned NUM_FU = 4;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned IDXW   = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic squash = 1'b0;

  cdb_if #(.NUM_FU(NUM_FU), .XLEN(XLEN), .ROB_IDX_LEN(IDXW)) bus ();

  cdb #(.NUM_FU(NUM_FU), .XLEN(XLEN), .ROB_IDX_LEN(IDXW)) dut (
    .clock (clock),
    .reset (reset),
    .squash(squash),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // One record per cycle: inputs, expected fu_ready during the cycle, expected bus after the edge.
  typedef struct {
    logic        rst;
    logic        sq;
    logic [3:0]  v;
    logic [4:0]  ib;
    logic [31:0] vb;
    logic [3:0]  mp;
    logic        cr;
    logic [3:0]  rdy;
    logic        cv;
    logic [4:0]  idx;
    logic [31:0] val;
    logic        emp;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic rst, input logic sq, input logic [3:0] v,
                              input logic [4:0] ib, input logic [31:0] vb, input logic [3:0] mp,
                              input logic cr, input logic [3:0] rdy, input logic cv,
                              input logic [4:0] idx, input logic [31:0] val, input logic emp);
    vec_t r;
    r.rst = rst; r.sq = sq; r.v = v; r.ib = ib; r.vb = vb; r.mp = mp;
    r.cr = cr; r.rdy = rdy; r.cv = cv; r.idx = idx; r.val = val; r.emp = emp;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] exp_v;
  logic [3:0]  acc;
  int unsigned seq0, seq1, nb0, nb1, thr;
  int          prev_fu, fu;

  initial begin
    bus.fu_valid     = '0;
    bus.fu_entry_idx = '0;
    bus.fu_value     = '0;
    bus.fu_mis_pred  = '0;

    //            rst sq v        ib     vb            mp     cr rdy    cv idx    val      emp
    // reset held two cycles with every FU valid
    tbl.push_back(mk(1, 0, 4'b1111, 5'd0, 32'h0, 4'b0000, 0, 4'b0000, 0, 5'd0, 32'h0, 0));
    tbl.push_back(mk(1, 0, 4'b1111, 5'd0, 32'h0, 4'b0000, 0, 4'b0000, 0, 5'd0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 5'd0, 32'h0, 4'b0000, 1, 4'b1111, 0, 5'd0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 5'd0, 32'h0, 4'b0000, 1, 4'b1111, 0, 5'd0, 32'h0, 0));
    // single completion on FU2: idx 7, DEADBEEF, two-edge latency
    tbl.push_back(mk(0, 0, 4'b0100, 5'd5, 32'hDEAD_BEED, 4'b0000, 1, 4'b1111, 0, 5'd0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 5'd0, 32'h0, 4'b0000, 1, 4'b1111, 1, 5'd7, 32'hDEAD_BEEF, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 5'd0, 32'h0, 4'b0000, 1, 4'b1111, 0, 5'd7, 32'hDEAD_BEEF, 0));
    // mispredict on FU1: idx 3
    tbl.push_back(mk(0, 0, 4'b0010, 5'd2, 32'h100, 4'b0010, 1, 4'b1111, 0, 5'd7, 32'hDEAD_BEEF, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 5'd0, 32'h0, 4'b0000, 1, 4'b1111, 1, 5'd3, 32'h101, 1));
    tbl.push_back(mk(0, 0, 4'b0000, 5'd0, 32'h0, 4'b0000, 1, 4'b1111, 0, 5'd3, 32'h101, 1));
    // reset mid-operation, then contention of FU0/FU1/FU3 from rr_ptr 0
    tbl.push_back(mk(1, 0, 4'b0000, 5'd0, 32'h0, 4'b0000, 0, 4'b0000, 0, 5'd0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 4'b1011, 5'd8, 32'h200, 4'b0000, 1, 4'b1111, 0, 5'd0, 32'h0, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 5'd0, 32'h0, 4'b0000, 1, 4'b0101, 1, 5'd8, 32'h200, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 5'd0, 32'h0, 4'b0000, 1, 4'b0111, 1, 5'd9, 32'h201, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 5'd0, 32'h0, 4'b0000, 1, 4'b1111, 1, 5'd11, 32'h203, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 5'd0, 32'h0, 4'b0000, 1, 4'b1111, 0, 5'd11, 32'h203, 0));
    // rr_ptr wrapped to 0: FU0 wins over FU1
    tbl.push_back(mk(0, 0, 4'b0011, 5'd16, 32'h300, 4'b0000, 1, 4'b1111, 0, 5'd11, 32'h203, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 5'd0, 32'h0, 4'b0000, 1, 4'b1101, 1, 5'd16, 32'h300, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 5'd0, 32'h0, 4'b0000, 1, 4'b1111, 1, 5'd17, 32'h301, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 5'd0, 32'h0, 4'b0000, 1, 4'b1111, 0, 5'd17, 32'h301, 0));
    // fill three slots, squash, buffered entries never appear
    tbl.push_back(mk(0, 0, 4'b1110, 5'd20, 32'h400, 4'b0000, 1, 4'b1111, 0, 5'd17, 32'h301, 0));
    tbl.push_back(mk(0, 1, 4'b0000, 5'd0, 32'h0, 4'b0000, 1, 4'b1111, 0, 5'd17, 32'h301, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 5'd0, 32'h0, 4'b0000, 1, 4'b1111, 0, 5'd17, 32'h301, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 5'd0, 32'h0, 4'b0000, 1, 4'b1111, 0, 5'd17, 32'h301, 0));
    tbl.push_back(mk(0, 0, 4'b0010, 5'd29, 32'h500, 4'b0000, 1, 4'b1111, 0, 5'd17, 32'h301, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 5'd0, 32'h0, 4'b0000, 1, 4'b1111, 1, 5'd30, 32'h501, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 5'd0, 32'h0, 4'b0000, 1, 4'b1111, 0, 5'd30, 32'h501, 0));
    // squash drops completions offered on the same edge
    tbl.push_back(mk(0, 1, 4'b1111, 5'd0, 32'h600, 4'b0000, 1, 4'b1111, 0, 5'd30, 32'h501, 0));
    tbl.push_back(mk(0, 0, 4'b0000, 5'd0, 32'h0, 4'b0000, 1, 4'b1111, 0, 5'd30, 32'h501, 0));

    foreach (tbl[k]) begin
      reset  = tbl[k].rst;
      squash = tbl[k].sq;
      for (int i = 0; i < 4; i++) begin
        bus.fu_valid[i]     = tbl[k].v[i];
        bus.fu_entry_idx[i] = tbl[k].ib + 5'(i);
        bus.fu_value[i]     = tbl[k].vb + 32'(i);
        bus.fu_mis_pred[i]  = tbl[k].mp[i];
      end
      #1;
      if (tbl[k].cr) check($sformatf("v%0d fu_ready", k), 64'(bus.fu_ready), 64'(tbl[k].rdy));
      @(posedge clock);
      #1;
      check($sformatf("v%0d cdb_valid", k), 64'(bus.cdb_valid), 64'(tbl[k].cv));
      check($sformatf("v%0d cdb_entry_idx", k), 64'(bus.cdb_entry_idx), 64'(tbl[k].idx));
      check($sformatf("v%0d cdb_value", k), 64'(bus.cdb_value), 64'(tbl[k].val));
      check($sformatf("v%0d cdb_mis_pred", k), 64'(bus.cdb_mis_pred), 64'(tbl[k].emp));
    end

    // FU0 and FU1 stream continuously for 20 cycles, then drain.
    reset = 1'b0; squash = 1'b0;
    seq0 = 0; seq1 = 0; nb0 = 0; nb1 = 0; thr = 0; prev_fu = -1;
    bus.fu_valid = '0;
    for (int c = 0; c < 30; c++) begin
      bus.fu_valid        = (c < 20) ? 4'b0011 : 4'b0000;
      bus.fu_entry_idx[0] = 5'(seq0);
      bus.fu_value[0]     = {16'd0, 16'(seq0)};
      bus.fu_entry_idx[1] = 5'(seq1);
      bus.fu_value[1]     = {16'd1, 16'(seq1)};
      bus.fu_mis_pred     = '0;
      #3;
      acc = bus.fu_valid & bus.fu_ready;
      @(posedge clock);
      #1;
      if (acc[0]) begin q0.push_back({16'd0, 16'(seq0)}); seq0++; end
      if (acc[1]) begin q1.push_back({16'd1, 16'(seq1)}); seq1++; end
      if (c >= 1 && c <= 20 && bus.cdb_valid) thr++;
      if (bus.cdb_valid) begin
        fu = int'(bus.cdb_value[31:16]);
        if (fu == 0 && q0.size() > 0) begin
          exp_v = q0.pop_front();
          nb0++;
        end else if (fu == 1 && q1.size() > 0) begin
          exp_v = q1.pop_front();
          nb1++;
        end else begin
          exp_v = 32'hFFFF_FFFF;
        end
        check($sformatf("fair c%0d value", c), 64'(bus.cdb_value), 64'(exp_v));
        check($sformatf("fair c%0d idx", c), 64'(bus.cdb_entry_idx), 64'(exp_v[4:0]));
        if (prev_fu >= 0) check($sformatf("fair c%0d alternate", c), 64'(fu), 64'(1 - prev_fu));
        prev_fu = fu;
      end
    end
    check("fair q0 drained", 64'(q0.size()), 64'd0);
    check("fair q1 drained", 64'(q1.size()), 64'd0);
    check("fair fu0 count", 64'(nb0), 64'(seq0));
    check("fair fu1 count", 64'(nb1), 64'(seq1));
    check("fair fu0 served", 64'(nb0 >= 10), 64'd1);
    check("fair fu1 served", 64'(nb1 >= 10), 64'd1);
    check("fair throughput", 64'(thr), 64'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/cdb.md
# cdb

Common data bus arbiter between the functional units and the reorder buffer. Each FU completion is captured in a one-entry holding slot. One completion per cycle is selected round-robin and registered onto the broadcast bus, which drives the ROB completion input (completed, entry index, value, mispredict flag), the reservation stations and the map table. FUs receive per-slot back-pressure; a ROB squash flushes everything in flight.

## Interface
Parameters:
- NUM_FU, 4, number of FU completion ports (≥2)
- XLEN, 32, result value width
- ROB_IDX_LEN, 5, ROB entry index width

Ports:
- clock  in  1  single clock, rising-edge
- reset  in  1  synchronous, active-high
- squash  in  1  ROB mispredict flush, same cycle as ROB asserts it
- fu_valid  in  NUM_FU  FU i presents a completion
- fu_entry_idx  in  NUM_FU×ROB_IDX_LEN  ROB entry of the completion
- fu_value  in  NUM_FU×XLEN  result value
- fu_mis_pred  in  NUM_FU  branch resolved mispredicted
- fu_ready  out  NUM_FU  slot i can accept this cycle (combinational)
- cdb_valid  out  1  broadcast valid (drives ROB completed)
- cdb_entry_idx  out  ROB_IDX_LEN  broadcast ROB index
- cdb_value  out  XLEN  broadcast value
- cdb_mis_pred  out  1  broadcast mispredict flag

## Operation
- Per FU: holding slot {valid, entry_idx, value, mis_pred}.
- Handshake: transfer on fu_valid[i] && fu_ready[i] at a rising edge. fu_ready[i] = !slot_valid[i] || grant[i]. A slot may drain and refill on the same edge.
- Arbitration candidates: occupied slots. One-hot grant. Search starts at rr_ptr and wraps modulo NUM_FU. At most one grant per cycle.
- rr_ptr update: after a grant to i, rr_ptr ← (i+1) mod NUM_FU. With no grant it is unchanged. Reset value is 0. squash does not modify rr_ptr.
- Broadcast register: on each edge it loads the granted slot's fields with cdb_valid=1. If nothing is granted, cdb_valid←0 and the data fields hold their previous values.
- Squash (when squash=1 at an edge):
  - all slot_valid←0 and cdb_valid←0.
  - Inputs on that edge are dropped; fu_ready is forced all-ones so FUs do not stall.
  - No grant is taken.
- Reset:
  - cdb_valid=0, cdb_entry_idx=0, cdb_value=0, cdb_mis_pred=0.
  - All slots empty, rr_ptr=0.
  - fu_ready reads all-ones in the cycle after reset.
- Reset mid-operation discards all slots and the broadcast register on that edge.
- cdb_mis_pred is passed through unchanged. This block does not generate squash.

## Timing
- Default latency is 2 edges from handshake to broadcast: accepted at edge t, arbitrated during cycle t+1, cdb_valid high during the cycle after edge t+1.
- Throughput is 1 broadcast per cycle.
- With all NUM_FU slots continuously full, each FU is granted exactly once every NUM_FU cycles.
- A slot waits at most NUM_FU−1 cycles for a grant.
- cdb_* outputs are registered. fu_ready is combinational from slot state and the grant vector; it has no path from fu_valid, even when bypass is enabled.

## Configuration
- CDB_BYPASS_EN defined:
  - An empty slot whose fu_valid=1 is also a candidate in the same cycle, so handshake-to-broadcast latency is 1 edge.
  - A bypass winner never occupies its slot; a bypass loser is written into its slot as normal.
  - Arbitration order and rr_ptr rules are unchanged.
  - fu_ready stays independent of fu_valid.
- Undefined: only occupied slots compete; latency is 2.

## Test plan
- Reset: hold reset 2 cycles with fu_valid=4'b1111 → cdb_valid=0, all cdb fields 0, no slot captured. fu_ready=4'b1111 after reset deasserts.
- Single completion: FU2 sends idx=7, value=32'hDEAD_BEEF, mis_pred=0 at edge t → cdb_valid=1, idx=7, value=DEADBEEF after edge t+1 (t without bypass... t+1), exactly one cycle. With CDB_BYPASS_EN, the same data appears after edge t.
- Contention: FU0, FU1, FU3 all complete at the same edge with rr_ptr=0 → broadcasts in order FU0, FU1, FU3 on consecutive cycles, then rr_ptr=0. fu_ready[3] stays 0 until its grant cycle.
- Back-pressure fairness: FU0 and FU1 hold fu_valid=1 continuously with incrementing indices → broadcasts alternate FU0/FU1. Each FU's indices appear in order with no drops or duplicates over 20 cycles.
- Squash mid-flight: fill 3 slots, assert squash for 1 cycle → cdb_valid=0 the following cycle. The buffered entries never appear. A new FU1 completion afterwards broadcasts normally.
- Mispredict passthrough: FU1 sends idx=3, mis_pred=1 → cdb_mis_pred=1 with idx=3 for one cycle, 0 otherwise.
